// File: rtl/pci_slave_pkg.sv
// Shared definitions for the PCI target slice: command codes, FSM encoding
// and default geometry.
package pci_pkg;

  localparam int          DEF_DEPTH     = 16;
  localparam int          IDX_W         = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_C9C0;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  function automatic logic is_read_cmd(input logic [3:0] cmd);
    return (cmd == CMD_IO_RD) || (cmd == CMD_MEM_RD);
  endfunction

  function automatic logic is_write_cmd(input logic [3:0] cmd);
    return (cmd == CMD_IO_WR) || (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_slave_mem.sv
// 16x32 target storage: byte-enabled write, asynchronous read, and each
// word reset to its own index.
module pci_slave_mem
  import pci_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage array with reset-to-index initialisation and per-byte writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'(i);
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pci_slave.sv
// PCI target with a 16-word claim window: IDLE/TURN/DATA handshake FSM and
// the AD tristate, backed by pci_slave_mem.
module pci_slave
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DEPTH     = DEF_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  inout  wire  [31:0] AD,
  input  logic [3:0]  CBE,
  input  logic        FRAME,
  input  logic        IRDY,
  output logic        TRDY,
  output logic        DEVSEL
);

  logic [1:0]       state_q, state_d;
  logic             trdy_q, trdy_d;
  logic             devsel_q, devsel_d;
  logic             oe_q, oe_d;
  logic             rd_q, rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mem_we_s;
  logic             hit_s;
  logic             xfer_s;
  logic [31:0]      rdata_s;

  assign hit_s  = (AD[31:4] == BASE_ADDR[31:4]) && (is_read_cmd(CBE) || is_write_cmd(CBE));
  assign xfer_s = (state_q == ST_DATA) && !IRDY && !trdy_q;

  // Next-state logic; every path back to IDLE releases the bus and deasserts the handshake.
  always_comb begin
    state_d  = state_q;
    trdy_d   = trdy_q;
    devsel_d = devsel_q;
    oe_d     = oe_q;
    rd_d     = rd_q;
    idx_d    = idx_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!FRAME && hit_s) begin
          idx_d    = AD[IDX_W-1:0];
          devsel_d = 1'b0;
          rd_d     = is_read_cmd(CBE);
          if (is_read_cmd(CBE)) begin
            state_d = ST_TURN;
          end else begin
            state_d = ST_DATA;
            trdy_d  = 1'b0;
          end
        end else begin
          trdy_d   = 1'b1;
          devsel_d = 1'b1;
          oe_d     = 1'b0;
        end
      end
      ST_TURN: begin
        if (FRAME && IRDY) begin
          state_d  = ST_IDLE;
          trdy_d   = 1'b1;
          devsel_d = 1'b1;
          oe_d     = 1'b0;
        end else begin
          state_d = ST_DATA;
          trdy_d  = 1'b0;
          oe_d    = 1'b1;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          idx_d    = idx_q + 4'd1;
          mem_we_s = !rd_q;
        end else begin
          idx_d = idx_q;
        end
        // FRAME high ends the burst whether it is the last transfer or an abort.
        if (FRAME) begin
          state_d  = ST_IDLE;
          trdy_d   = 1'b1;
          devsel_d = 1'b1;
          oe_d     = 1'b0;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        trdy_d   = 1'b1;
        devsel_d = 1'b1;
        oe_d     = 1'b0;
      end
    endcase
  end

  // Control registers with asynchronous bus release on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      trdy_q   <= 1'b1;
      devsel_q <= 1'b1;
      oe_q     <= 1'b0;
      rd_q     <= 1'b0;
      idx_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      trdy_q   <= trdy_d;
      devsel_q <= devsel_d;
      oe_q     <= oe_d;
      rd_q     <= rd_d;
      idx_q    <= idx_d;
    end
  end

  pci_slave_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (CLK),
    .rst_ni (RST),
    .we_i   (mem_we_s),
    .be_i   (~CBE),
    .addr_i (idx_q),
    .wdata_i(AD),
    .rdata_o(rdata_s)
  );

  assign AD     = oe_q ? rdata_s : 32'bz;
  assign TRDY   = trdy_q;
  assign DEVSEL = devsel_q;

endmodule

// File: tb/tb_pci_slave.sv
// Directed bench for pci_slave: vector table plus hand sequences for reset
// and abort. The bus has weak pull-ups, so a released AD reads all ones.
module tb_pci_slave;

  localparam logic [31:0] REL = 32'hFFFF_FFFF;

  typedef struct {
    logic        frame;
    logic        irdy;
    logic [3:0]  cbe;
    logic        oe;
    logic [31:0] ad;
    logic        trdy;
    logic        devsel;
    logic [31:0] exp_ad;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  CBE;
  logic        FRAME;
  logic        IRDY;
  logic        TRDY;
  logic        DEVSEL;
  logic        tb_oe;
  logic [31:0] tb_ad;
  tri1  [31:0] ad_w;

  int passed = 0;
  int total  = 0;

  vec_t vecs [25];

  assign ad_w = tb_oe ? tb_ad : 32'bz;

  pci_slave dut (
    .CLK   (CLK),
    .RST   (RST),
    .AD    (ad_w),
    .CBE   (CBE),
    .FRAME (FRAME),
    .IRDY  (IRDY),
    .TRDY  (TRDY),
    .DEVSEL(DEVSEL)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic f, input logic i, input logic [3:0] c,
                              input logic o, input logic [31:0] a, input logic t,
                              input logic d, input logic [31:0] e);
    vec_t v;
    v.frame = f; v.irdy = i; v.cbe = c; v.oe = o; v.ad = a;
    v.trdy = t; v.devsel = d; v.exp_ad = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic t, input logic d, input logic [31:0] a);
    check({tag, " TRDY"},   {31'd0, TRDY},   {31'd0, t});
    check({tag, " DEVSEL"}, {31'd0, DEVSEL}, {31'd0, d});
    check({tag, " AD"},     ad_w,            a);
  endtask

  task automatic apply(input string tag, input vec_t v);
    FRAME = v.frame;
    IRDY  = v.irdy;
    CBE   = v.cbe;
    tb_oe = v.oe;
    tb_ad = v.ad;
    @(posedge CLK);
    #1;
    tb_oe = 1'b0;
    #1;
    check_outs(tag, v.trdy, v.devsel, v.exp_ad);
  endtask

  task automatic read1(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    apply({tag, " addr"}, mk(1'b0, 1'b1, 4'b0110, 1'b1, addr, 1'b1, 1'b0, REL));
    apply({tag, " data"}, mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0, 1'b0, 1'b0, exp));
    apply({tag, " end"},  mk(1'b1, 1'b0, 4'b0000, 1'b0, 32'd0, 1'b1, 1'b1, REL));
  endtask

  initial begin
    // read burst 0xC9C5 -> 5,6,7
    vecs[0]  = mk(1'b0, 1'b1, 4'b0010, 1'b1, 32'h0000_C9C5, 1'b1, 1'b0, REL);
    vecs[1]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd5);
    vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd6);
    vecs[3]  = mk(1'b0, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd7);
    vecs[4]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);
    // byte-enabled write to word 2, then read back
    vecs[5]  = mk(1'b0, 1'b1, 4'b0011, 1'b1, 32'h0000_C9C2, 1'b0, 1'b0, REL);
    vecs[6]  = mk(1'b1, 1'b0, 4'b1100, 1'b1, 32'hAABB_CCDD, 1'b1, 1'b1, REL);
    vecs[7]  = mk(1'b0, 1'b1, 4'b0110, 1'b1, 32'h0000_C9C2, 1'b1, 1'b0, REL);
    vecs[8]  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'h0000_CCDD);
    vecs[9]  = mk(1'b1, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);
    // address miss and unsupported command
    vecs[10] = mk(1'b0, 1'b1, 4'b0110, 1'b1, 32'h0001_0000, 1'b1, 1'b1, REL);
    vecs[11] = mk(1'b1, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);
    vecs[12] = mk(1'b0, 1'b1, 4'b0000, 1'b1, 32'h0000_C9C5, 1'b1, 1'b1, REL);
    vecs[13] = mk(1'b1, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);
    // full-word memory write to word 8, I/O read back-to-back
    vecs[14] = mk(1'b0, 1'b1, 4'b0111, 1'b1, 32'h0000_C9C8, 1'b0, 1'b0, REL);
    vecs[15] = mk(1'b1, 1'b0, 4'b0000, 1'b1, 32'h1234_5678, 1'b1, 1'b1, REL);
    vecs[16] = mk(1'b0, 1'b1, 4'b0010, 1'b1, 32'h0000_C9C8, 1'b1, 1'b0, REL);
    vecs[17] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'h1234_5678);
    vecs[18] = mk(1'b1, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);
    // word 15 with initiator waits, then wrap to word 0
    vecs[19] = mk(1'b0, 1'b1, 4'b0110, 1'b1, 32'h0000_C9CF, 1'b1, 1'b0, REL);
    vecs[20] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd15);
    vecs[21] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd15);
    vecs[22] = mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd15);
    vecs[23] = mk(1'b0, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0);
    vecs[24] = mk(1'b1, 1'b0, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL);

    RST = 1'b0; FRAME = 1'b1; IRDY = 1'b1; CBE = 4'b0000; tb_oe = 1'b0; tb_ad = 32'd0;
    #12;
    check_outs("reset", 1'b1, 1'b1, REL);
    RST = 1'b1;

    for (int k = 0; k < 25; k++) begin
      apply($sformatf("vec%0d", k), vecs[k]);
    end

    // abort in TURN: bus released next edge, word 4 untouched
    apply("abort_turn addr", mk(1'b0, 1'b1, 4'b0110, 1'b1, 32'h0000_C9C4, 1'b1, 1'b0, REL));
    apply("abort_turn",      mk(1'b1, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b1, 1'b1, REL));
    read1("abort_turn rb", 32'h0000_C9C4, 32'd4);

    // abort in write DATA: the data on AD must not be written
    apply("abort_wr addr", mk(1'b0, 1'b1, 4'b0011, 1'b1, 32'h0000_C9C6, 1'b0, 1'b0, REL));
    apply("abort_wr",      mk(1'b1, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, REL));
    read1("abort_wr rb", 32'h0000_C9C6, 32'd6);

    // asynchronous reset in read DATA, memory re-initialised
    apply("rst_mid addr", mk(1'b0, 1'b1, 4'b0110, 1'b1, 32'h0000_C9C5, 1'b1, 1'b0, REL));
    apply("rst_mid data", mk(1'b0, 1'b1, 4'b0000, 1'b0, 32'd0,         1'b0, 1'b0, 32'd5));
    #3;
    RST = 1'b0;
    #1;
    check_outs("rst_mid async", 1'b1, 1'b1, REL);
    FRAME = 1'b1; IRDY = 1'b1;
    #1;
    RST = 1'b1;
    apply("rst_mid idle", mk(1'b1, 1'b1, 4'b0000, 1'b0, 32'd0, 1'b1, 1'b1, REL));
    read1("rst_mid rd3", 32'h0000_C9C3, 32'd3);
    read1("rst_mid rd2", 32'h0000_C9C2, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pci_slave.md
PCI_SLAVE -- requirements
Module: pci_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_C9C0, 16-word claim window; decode compares AD[31:4] with BASE_ADDR[31:4].
REQ-002 Parameter DEPTH, default 16, number of 32-bit storage words; it is fixed at 16 in this revision.
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port CLK: input, 1 bit, the clock; all sampling happens on its rising edge.
REQ-005 Port RST: input, 1 bit, the asynchronous active-low reset.
REQ-006 Port AD: inout, 32 bits, multiplexed address/data bus; the slave drives it only during read data phases and releases it (Z) otherwise.
REQ-007 Port CBE: input, 4 bits; it carries the command in the address phase and active-low byte enables in data phases.
REQ-008 Port FRAME: input, 1 bit, active-low; low means the transaction is in progress, high means the final data phase.
REQ-009 Port IRDY: input, 1 bit, active-low initiator ready.
REQ-010 Port TRDY: output, 1 bit, active-low target ready; it is driven 1 when idle.
REQ-011 Port DEVSEL: output, 1 bit, active-low device select; it is driven 1 when idle.

Function
REQ-012 The block SHALL have three states: IDLE, TURN (read turnaround) and DATA.
REQ-013 In IDLE, a rising edge with FRAME=0 is the address phase; the block SHALL latch AD and CBE at that edge.
REQ-014 Commands: 0010 (I/O read) and 0110 (memory read) SHALL be reads; 0011 (I/O write) and 0111 (memory write) SHALL be writes; all other commands SHALL be ignored and the block SHALL stay in IDLE.
REQ-015 Hit SHALL be defined as AD[31:4]==BASE_ADDR[31:4] with a supported command; on a miss the block SHALL stay in IDLE and leave DEVSEL=1.
REQ-016 On a hit, the block SHALL load the word index from AD[3:0] and drive DEVSEL=0 from the address edge onward.
REQ-017 On a read hit, the block SHALL go to TURN for one cycle with TRDY=1 and AD=Z, then to DATA.
REQ-018 On a write hit, the block SHALL go directly to DATA.
REQ-019 In DATA, TRDY SHALL be 0; no target wait states are inserted.
REQ-020 In read DATA, AD SHALL be driven with mem[index] (all 4 bytes, CBE ignored).
REQ-021 A transfer SHALL occur on a rising edge where IRDY=0 and TRDY=0.
REQ-022 On a write transfer, the block SHALL update only the bytes whose CBE bit is 0 (CBE[n] gates AD[8n+7:8n]).
REQ-023 After each transfer the index SHALL increment by 1, wrapping 15 to 0.
REQ-024 While IRDY=1, the block SHALL hold the index, the AD data and the state (initiator wait state).
REQ-025 A transfer with FRAME=1 is the last data phase; the block SHALL then return to IDLE, set TRDY=1 and DEVSEL=1, and release AD on the following edge.
REQ-026 FRAME=1 together with IRDY=1 in TURN or DATA is an initiator abort; the block SHALL return to IDLE with no transfer.
REQ-027 The block SHALL never drive AD while in IDLE or during the address phase, and never during writes.
REQ-028 A new address phase SHALL be accepted on the first edge in IDLE where FRAME=0; back-to-back transactions are allowed.

Reset
REQ-029 When RST=0, the block SHALL immediately (asynchronously) enter IDLE, set TRDY=1 and DEVSEL=1, and release AD to Z.
REQ-030 During reset, the block SHALL initialise mem[i]=i for i=0..15 and set index=0.
REQ-031 A reset in the middle of a transaction SHALL abort it; the block SHALL resume on the first FRAME=0 edge after RST returns to 1.

Structure
REQ-032 A shared package pci_pkg SHALL hold the command codes, the state encoding and the defaults DEPTH=16 and BASE_ADDR.
REQ-033 The storage SHALL be a single sub-module pci_slave_mem: 16x32 array with byte-enabled write, asynchronous read and a reset-to-index initialiser; the FSM and AD tristate stay in pci_slave.

Verification
REQ-034 Read burst: address 51653 (0xC9C5), CBE=0010, IRDY=0 for 3 edges, FRAME raised before the third -> DEVSEL=0 after the address edge, TRDY=0 one cycle later, AD returns 5, 6, 7, then TRDY, DEVSEL and AD go back to 1, 1, Z.
REQ-035 Write with byte enables: write to 0xC9C2, CBE=0011, data 0xAABBCCDD with CBE=1100, then a read-back -> mem[2]=0x0000CCDD.
REQ-036 Miss/unsupported: address 0x0001_0000, or command 0000 at 0xC9C5 -> DEVSEL and TRDY stay 1, AD stays Z.
REQ-037 Wait states and wrap: read at 0xC9CF with IRDY=1 for 2 cycles between phases -> AD holds 15 through the wait, the next transfer returns 0.
REQ-038 Reset mid-burst: RST=0 during read DATA -> TRDY=1, DEVSEL=1 and AD=Z immediately; a later read at 0xC9C3 returns 3.
REQ-039 Abort: FRAME=1 with IRDY=1 during TURN -> IDLE on the next edge with no memory change.
